// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit common-anode display path
// (hex-to-segment stage and the scan driver).
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t                  SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/seg_scan_driver_scan_prescaler.sv
// Slot timer for the display scan: counts clk cycles within a digit slot and
// steps the digit index 0->1->2->3->0 each time the slot counter wraps.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [$clog2(DIGIT_CYCLES)-1:0]     cnt,
    output logic [IDX_W-1:0]                    idx,
    output logic                                slot_start,
    output logic                                frame_start
);

    localparam int                CNT_W   = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt         = cnt_q;
    assign idx         = idx_q;
    assign slot_start  = (cnt_q == '0);
    assign frame_start = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a packed 4-digit segment word onto one cathode bus and four
// anode selects. Optional ghost-suppression blanking is enabled by SCAN_BLANK_EN.
module seg_scan_driver
    import display_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] display,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             slot_start;
    logic             frame_start;
    logic             blank;

    logic [NUM_DIGITS*SEG_W-1:0] frame_q, frame_d;
    logic [NUM_DIGITS-1:0]       en_q, en_d;
    seg_t                        seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;

    scan_prescaler #(
        .DIGIT_CYCLES (DIGIT_CYCLES)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt),
        .idx         (idx),
        .slot_start  (slot_start),
        .frame_start (frame_start)
    );

`ifdef SCAN_BLANK_EN
    if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_blank_check
        $error("seg_scan_driver: BLANK_CYCLES must be less than DIGIT_CYCLES");
    end
    assign blank = (32'(cnt) < BLANK_CYCLES);
    logic unused_slot;
    assign unused_slot = slot_start;
`else
    assign blank = 1'b0;
    logic unused_scan;
    assign unused_scan = ^{cnt, slot_start};
`endif

    // Slot 0's first cycle decodes from the incoming snapshot so a new frame
    // is visible on the pins from its very first slot.
    always_comb begin
        frame_d = frame_q;
        en_d    = en_q;
        if (frame_start) begin
            frame_d = display;
            en_d    = digit_en;
        end
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (en_d[idx] && !blank) begin
            seg_d = frame_d[idx*SEG_W +: SEG_W];
            an_d  = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '1;
            en_q    <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            frame_q <= frame_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_start && !rst;

endmodule
